game_event_gen: RTL and testbench

GAME_EVENT_GEN -- requirements
Module: game_event_gen

---
 rtl/game_event_gen.sv | 126 ++++++++++++
 tb/tb_game_event_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_event_gen.sv
// Game event generator: synchronizes and debounces the start button and hoop sensor,
// and runs the game countdown timer that emits start, score and expiry pulses.
module game_event_gen #(
  parameter int unsigned GAME_SECONDS    = 30,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 100_000_000
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       hoop_sensor,
  input  logic       game_active,
  output logic       startGame,
  output logic       player_scored,
  output logic       timer_expired,
  output logic [5:0] time_left
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PsW = $clog2(TICK_CYCLES);
  localparam logic [DbW-1:0] DbMax    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PsW-1:0] PsMax    = PsW'(TICK_CYCLES - 1);
  localparam logic [5:0]     GameSecs = 6'(GAME_SECONDS);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  // Bit 0 carries start_btn, bit 1 carries hoop_sensor.
  logic [1:0]     raw;
  logic [1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]     lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];
  logic [1:0]     rise;

  state_e         state_q, state_d;
  logic [5:0]     time_left_q, time_left_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic           start_game_q, start_game_d;
  logic           player_scored_q, player_scored_d;
  logic           timer_expired_q, timer_expired_d;

  assign raw = {hoop_sensor, start_btn};

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // One-cycle event on each debounced rising edge.
  assign rise = lvl_q & ~lvl_prev_q;

  always_comb begin
    state_d         = state_q;
    time_left_d     = time_left_q;
    presc_d         = presc_q;
    start_game_d    = 1'b0;
    timer_expired_d = 1'b0;
    player_scored_d = rise[1] && (state_q == StRun);
    if (state_q == StRun) begin
      if (presc_q == PsMax) begin
        presc_d = '0;
        if (time_left_q == 6'd1) begin
          time_left_d     = '0;
          timer_expired_d = 1'b1;
          state_d         = StExpired;
        end else begin
          time_left_d = time_left_q - 6'd1;
        end
      end else begin
        presc_d = presc_q + PsW'(1);
      end
    end else if (rise[0] && !game_active) begin
      // Starts outside RUN are accepted only while the game FSM is idle; others are dropped.
      start_game_d = 1'b1;
      state_d      = StRun;
      time_left_d  = GameSecs;
      presc_d      = '0;
    end
  end

  always_ff @(posedge clkIn) begin
    if (reset) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      lvl_q           <= '0;
      lvl_prev_q      <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      state_q         <= StIdle;
      time_left_q     <= GameSecs;
      presc_q         <= '0;
      start_game_q    <= 1'b0;
      player_scored_q <= 1'b0;
      timer_expired_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      lvl_q           <= lvl_d;
      lvl_prev_q      <= lvl_prev_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q         <= state_d;
      time_left_q     <= time_left_d;
      presc_q         <= presc_d;
      start_game_q    <= start_game_d;
      player_scored_q <= player_scored_d;
      timer_expired_q <= timer_expired_d;
    end
  end

  assign startGame     = start_game_q;
  assign player_scored = player_scored_q;
  assign timer_expired = timer_expired_q;
  assign time_left     = time_left_q;

endmodule

// File: tb/tb_game_event_gen.sv
// Scoreboard bench for game_event_gen: a driver feeds directed and random stimulus into
// an arithmetic reference model; a monitor pops expected pulses and time_left per cycle.
module tb_game_event_gen;

  localparam int G = 3;
  localparam int N = 4;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst, start_btn, hoop, ga;
  logic       start_o, score_o, exp_o;
  logic [5:0] tl_o;

  game_event_gen #(
    .GAME_SECONDS(G),
    .DEBOUNCE_CYCLES(N),
    .TICK_CYCLES(T)
  ) dut (
    .clkIn(clk),
    .reset(rst),
    .start_btn(start_btn),
    .hoop_sensor(hoop),
    .game_active(ga),
    .startGame(start_o),
    .player_scored(score_o),
    .timer_expired(exp_o),
    .time_left(tl_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit st;
    bit sc;
    bit ex;
  } ev_t;

  ev_t        ev_q[$];
  logic [5:0] tl_q[$];
  int         checks = 0;
  int         failures = 0;
  int         edge_cnt = 0;
  bit         mon_en = 1'b1;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model state: two-deep input delay, debounce run lengths, game mode/start edge.
  bit         m_d1[2], m_d2[2], m_lvl[2], m_rose[2];
  int         m_cnt[2];
  int         m_mode = 0;  // 0 idle, 1 run, 2 expired
  int         m_start = 0;
  logic [5:0] m_tl = 6'(G);

  task automatic model_step(input int k, input bit r, input bit s, input bit h, input bit g);
    bit  raw[2];
    bit  smp, ev_s, ev_h, p_st, p_sc, p_ex;
    int  el;
    ev_t e;
    raw[0] = s;
    raw[1] = h;
    p_st = 1'b0;
    p_sc = 1'b0;
    p_ex = 1'b0;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_cnt[i] = 0; m_rose[i] = 0;
      end
      m_mode = 0;
      m_tl   = 6'(G);
    end else begin
      ev_s = m_rose[0];
      ev_h = m_rose[1];
      for (int i = 0; i < 2; i++) begin
        smp       = m_d2[i];
        m_d2[i]   = m_d1[i];
        m_d1[i]   = raw[i];
        m_rose[i] = 1'b0;
        if (smp == m_lvl[i]) begin
          m_cnt[i] = 0;
        end else begin
          m_cnt[i]++;
          if (m_cnt[i] == N) begin
            m_lvl[i]  = smp;
            m_cnt[i]  = 0;
            m_rose[i] = smp;
          end
        end
      end
      p_sc = ev_h && (m_mode == 1);
      if (m_mode == 1) begin
        el = k - m_start;
        if (el >= G * T) begin
          m_tl   = 6'd0;
          p_ex   = 1'b1;
          m_mode = 2;
        end else begin
          m_tl = 6'(G - el / T);
        end
      end else if (ev_s && !g) begin
        p_st    = 1'b1;
        m_mode  = 1;
        m_start = k;
        m_tl    = 6'(G);
      end
    end
    tl_q.push_back(m_tl);
    if (p_st || p_sc || p_ex) begin
      e.cyc = k; e.st = p_st; e.sc = p_sc; e.ex = p_ex;
      ev_q.push_back(e);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit h, input bit g);
    rst       = r;
    start_btn = s;
    hoop      = h;
    ga        = g;
    model_step(edge_cnt + 1, r, s, h, g);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mode(input int md, input int budget);
    int n = 0;
    while (m_mode != md && n < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_mode != md) begin
      checks++;
      failures++;
      $display("FAIL wait_mode got=%0d exp=%0d", m_mode, md);
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t        e;
    logic [5:0] et;
    if (mon_en && edge_cnt > 0) begin
      checks++;
      if (tl_q.size() == 0) begin
        failures++;
        $display("FAIL tl_queue cyc=%0d got=empty exp=entry", edge_cnt);
      end else begin
        et = tl_q.pop_front();
        if (tl_o !== et) begin
          failures++;
          $display("FAIL time_left cyc=%0d got=%0d exp=%0d", edge_cnt, tl_o, et);
        end
      end
      while (ev_q.size() > 0 && ev_q[0].cyc < edge_cnt) begin
        e = ev_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_pulse cyc=%0d got=none exp=st%0b sc%0b ex%0b",
                 e.cyc, e.st, e.sc, e.ex);
      end
      if ((start_o | score_o | exp_o) !== 1'b0 ||
          (ev_q.size() > 0 && ev_q[0].cyc == edge_cnt)) begin
        if (ev_q.size() > 0 && ev_q[0].cyc == edge_cnt) begin
          e = ev_q.pop_front();
        end else begin
          e.cyc = edge_cnt; e.st = 1'b0; e.sc = 1'b0; e.ex = 1'b0;
        end
        checks++;
        if ({start_o, score_o, exp_o} !== {e.st, e.sc, e.ex}) begin
          failures++;
          $display("FAIL pulses cyc=%0d got=st%0b sc%0b ex%0b exp=st%0b sc%0b ex%0b",
                   edge_cnt, start_o, score_o, exp_o, e.st, e.sc, e.ex);
        end
      end
    end
  end

  initial begin
    bit rs = 1'b0, rh = 1'b0, rg = 1'b0;
    int hs = 0, hh = 0, hg = 0;
    int n;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Bouncing start button must never get through.
    for (int i = 0; i < 20; i++) step(1'b0, 1'((i / 2) % 2), 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Start, two scores during the game, countdown to expiry, then an ignored score.
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    wait_mode(2, 100);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Hoop edge timed to land on the expiring wrap.
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
    wait_mode(1, 50);
    n = 0;
    while (edge_cnt + 1 < m_start + G * T - 6 && n < 100) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
    wait_mode(2, 100);

    // Blocked starts: during RUN, and in EXPIRED with game_active high; then a real restart.
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
    wait_mode(2, 100);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-game reset at time_left=2 aborts without an expiry pulse.
    n = 0;
    while (!(m_mode == 1 && m_tl == 6'd2) && n < 100) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random phase: held levels of random length, occasional game_active and reset.
    repeat (3000) begin
      if (hs == 0) begin rs = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 10); end
      if (hh == 0) begin rh = 1'($urandom_range(0, 1)); hh = $urandom_range(1, 10); end
      if (hg == 0) begin rg = ($urandom_range(0, 3) == 0); hg = $urandom_range(1, 40); end
      hs--; hh--; hg--;
      step(($urandom_range(0, 299) == 0), rs, rh, rg);
    end

    #6;
    mon_en = 1'b0;
    checks++;
    if (ev_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_pulses got=%0d exp=0", ev_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
